// File: rtl/alu_pkg.sv
// Shared definitions for the ALU lanes: opcode encodings and default width.
package alu_pkg;

   localparam int DEF_WIDTH = 4;

   localparam logic [2:0] OP_AND   = 3'b000;
   localparam logic [2:0] OP_OR    = 3'b001;
   localparam logic [2:0] OP_XOR   = 3'b010;
   localparam logic [2:0] OP_XNOR  = 3'b011;
   localparam logic [2:0] OP_NAND  = 3'b100;
   localparam logic [2:0] OP_NOR   = 3'b101;
   localparam logic [2:0] OP_NOTA  = 3'b110;
   localparam logic [2:0] OP_PASSB = 3'b111;

endpackage

// File: rtl/alu_logic_unit.sv
// Combinational logic function f(op, a, b) for the ALU logic lane.
module alu_logic_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] y_o
);

   logic [WIDTH-1:0] xnor_y;

   xnor_gate #(.WIDTH(WIDTH)) u_xnor (
      .a_i (a_i),
      .b_i (b_i),
      .y_o (xnor_y)
   );

   // Select one of the eight bitwise functions.
   always_comb begin
      y_o = '0;
      case (op_i)
         OP_AND:   y_o = a_i & b_i;
         OP_OR:    y_o = a_i | b_i;
         OP_XOR:   y_o = a_i ^ b_i;
         OP_XNOR:  y_o = xnor_y;
         OP_NAND:  y_o = ~(a_i & b_i);
         OP_NOR:   y_o = ~(a_i | b_i);
         OP_NOTA:  y_o = ~a_i;
         OP_PASSB: y_o = b_i;
         default:  y_o = '0;
      endcase
   end

endmodule

// File: rtl/xnor_gate.sv
// Bitwise XNOR of two vectors, one gate per bit.
module xnor_gate #(
   parameter int WIDTH = 1
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] y_o
);

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         assign y_o[gi] = ~(a_i[gi] ^ b_i[gi]);
      end
   endgenerate

endmodule

// File: rtl/alu_logic_pipe.sv
// Two-stage valid/ready pipe around the logic unit: operand register,
// result register with zero/ones flags, and a completed-transfer counter.
module alu_logic_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic [2:0]       op_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result_out,
   output logic             zero_out,
   output logic             ones_out,
   output logic [CNT_W-1:0] op_count
);

   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d;
   logic [WIDTH-1:0] s1_b_q, s1_b_d;
   logic [2:0]       s1_op_q, s1_op_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             ones_q, ones_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic             adv;
   logic             accept;
   logic             load_s2;
   logic             xfer_out;
   logic [WIDTH-1:0] f_val;

   alu_logic_unit #(.WIDTH(WIDTH)) u_unit (
      .op_i (s1_op_q),
      .a_i  (s1_a_q),
      .b_i  (s1_b_q),
      .y_o  (f_val)
   );

   // Handshake: result stage can take a new value when empty or draining;
   // no skid buffer, so in_ready depends combinationally on out_ready.
   assign adv      = !out_valid_q || out_ready;
   assign in_ready = rst_n && (!s1_valid_q || adv);
   assign accept   = in_valid && in_ready;
   assign load_s2  = s1_valid_q && adv;
   assign xfer_out = out_valid_q && out_ready;

   // Next-state for both stages and the counter; hold by default.
   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_a_d      = s1_a_q;
      s1_b_d      = s1_b_q;
      s1_op_d     = s1_op_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      zero_d      = zero_q;
      ones_d      = ones_q;
      count_d     = count_q;

      if (accept) begin
         s1_valid_d = 1'b1;
         s1_a_d     = a_in;
         s1_b_d     = b_in;
         s1_op_d    = op_in;
      end else if (load_s2) begin
         s1_valid_d = 1'b0;
      end

      // Flags come from the very value loaded into the result register.
      if (load_s2) begin
         out_valid_d = 1'b1;
         result_d    = f_val;
         zero_d      = (f_val == '0);
         ones_d      = (f_val == {WIDTH{1'b1}});
      end else if (xfer_out) begin
         out_valid_d = 1'b0;
      end

      if (xfer_out) begin
         count_d = count_q + 1'b1;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s1_op_q     <= '0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         ones_q      <= 1'b0;
         count_q     <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         s1_op_q     <= s1_op_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         ones_q      <= ones_d;
         count_q     <= count_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign result_out = result_q;
   assign zero_out   = zero_q;
   assign ones_out   = ones_q;
   assign op_count   = count_q;

endmodule

// File: tb/tb_alu_logic_pipe.sv
// Self-checking bench for alu_logic_pipe: directed steps plus random traffic
// against a truth-table / occupancy reference model.
module tb_alu_logic_pipe;
   import alu_pkg::*;

   localparam int W  = 4;
   localparam int CW = 8;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a_in;
   logic [W-1:0]  b_in;
   logic [2:0]    op_in;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  result_out;
   logic          zero_out;
   logic          ones_out;
   logic [CW-1:0] op_count;

   alu_logic_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a_in       (a_in),
      .b_in       (b_in),
      .op_in      (op_in),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result_out (result_out),
      .zero_out   (zero_out),
      .ones_out   (ones_out),
      .op_count   (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int val;
      int e_acc;
   } item_t;

   item_t       q[$];
   int          edges = 0;
   int          done_cnt = 0;
   int          tests = 0;
   int          fails = 0;
   logic [3:0]  tt [8];

   // Per-opcode truth table, bit index = {a_bit, b_bit}.
   function automatic int ref_f(input logic [2:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b);
      int r;
      logic [3:0] t;
      r = 0;
      t = tt[op];
      for (int i = 0; i < W; i++) begin
         if (t[{a[i], b[i]}]) r += (1 << i);
      end
      return r;
   endfunction

   task automatic check(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock of traffic: drive, check against model at negedge, update at posedge.
   task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] op, input logic ordy, output logic acc);
      int exp_rdy, exp_ov, hv;
      in_valid  = v;
      a_in      = a;
      b_in      = b;
      op_in     = op;
      out_ready = ordy;
      @(negedge clk);
      exp_rdy = ((q.size() < 2) || ordy) ? 1 : 0;
      exp_ov  = (q.size() > 0 && edges >= q[0].e_acc + 1) ? 1 : 0;
      check("in_ready", int'(in_ready), exp_rdy);
      check("out_valid", int'(out_valid), exp_ov);
      if (exp_ov == 1) begin
         hv = q[0].val;
         check("result", int'(result_out), hv);
         check("zero", int'(zero_out), (hv == 0) ? 1 : 0);
         check("ones", int'(ones_out), (hv == (1 << W) - 1) ? 1 : 0);
      end
      check("op_count", int'(op_count), done_cnt % (1 << CW));
      acc = v && (exp_rdy == 1);
      $display("[TB] t=%0t v=%0b op=%0d a=%0h b=%0h ordy=%0b rdy=%0b ov=%0b res=%0h cnt=%0d",
               $time, v, op, a, b, ordy, in_ready, out_valid, result_out, op_count);
      @(posedge clk);
      edges++;
      if (exp_ov == 1 && ordy) begin
         void'(q.pop_front());
         done_cnt++;
      end
      if (acc) q.push_back('{ref_f(op, a, b), edges});
      #1;
   endtask

   task automatic reset_pulse();
      rst_n    = 1'b0;
      in_valid = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      check("in_ready_in_reset", int'(in_ready), 0);
      @(posedge clk);
      edges++;
      q.delete();
      done_cnt = 0;
      #1;
      rst_n    = 1'b1;
      in_valid = 1'b0;
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_result", int'(result_out), 0);
      check("rst_zero", int'(zero_out), 0);
      check("rst_ones", int'(ones_out), 0);
      check("rst_op_count", int'(op_count), 0);
      $display("[TB] t=%0t reset pulse", $time);
   endtask

   initial begin
      logic acc;
      logic hold_v, h_ordy;
      logic [W-1:0] h_a, h_b;
      logic [2:0] h_op;
      logic pend;

      tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0110; tt[3] = 4'b1001;
      tt[4] = 4'b0111; tt[5] = 4'b0001; tt[6] = 4'b0011; tt[7] = 4'b1010;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a_in = '0; b_in = '0; op_in = '0;
      repeat (2) @(posedge clk);
      #1;
      reset_pulse();

      // Single XNOR giving all zeros, then an XNOR and an all-ones AND.
      step(1'b1, 4'b1010, 4'b0101, OP_XNOR, 1'b1, acc);
      repeat (3) step(1'b0, 4'b0, 4'b0, OP_AND, 1'b1, acc);
      step(1'b1, 4'b1100, 4'b1010, OP_XNOR, 1'b1, acc);
      step(1'b1, 4'b1111, 4'b1111, OP_AND, 1'b1, acc);
      repeat (3) step(1'b0, 4'b0, 4'b0, OP_AND, 1'b1, acc);

      // Back-to-back opcode sweep.
      for (int op = 0; op < 8; op++) step(1'b1, 4'b0110, 4'b0011, 3'(op), 1'b1, acc);
      repeat (3) step(1'b0, 4'b0, 4'b0, OP_AND, 1'b1, acc);

      // Backpressure: third op waits until the first drains.
      step(1'b1, 4'h1, 4'h2, OP_AND, 1'b0, acc);
      step(1'b1, 4'h3, 4'h4, OP_OR, 1'b0, acc);
      step(1'b1, 4'h5, 4'h6, OP_XOR, 1'b0, acc);
      check("third_held", int'(acc), 0);
      step(1'b1, 4'h5, 4'h6, OP_XOR, 1'b0, acc);
      step(1'b1, 4'h5, 4'h6, OP_XOR, 1'b1, acc);
      check("third_accept_on_drain", int'(acc), 1);
      repeat (4) step(1'b0, 4'b0, 4'b0, OP_AND, 1'b1, acc);

      // Reset with two operations in flight.
      step(1'b1, 4'h9, 4'h3, OP_NAND, 1'b0, acc);
      step(1'b1, 4'h7, 4'h8, OP_NOR, 1'b0, acc);
      reset_pulse();
      repeat (3) step(1'b0, 4'b0, 4'b0, OP_AND, 1'b1, acc);

      // Random traffic honouring the hold-while-stalled rule.
      pend = 1'b0; h_a = '0; h_b = '0; h_op = '0; hold_v = 1'b0; h_ordy = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!pend) begin
            hold_v = ($urandom_range(0, 9) < 7);
            h_a    = W'($urandom);
            h_b    = W'($urandom);
            h_op   = 3'($urandom);
         end
         h_ordy = ($urandom_range(0, 9) < 6);
         step(hold_v, h_a, h_b, h_op, h_ordy, acc);
         pend = hold_v && !acc;
      end
      repeat (3) step(1'b0, 4'b0, 4'b0, OP_AND, 1'b1, acc);

      // Full-throughput run long enough to wrap the counter.
      for (int i = 0; i < 270; i++) begin
         step(1'b1, W'($urandom), W'($urandom), 3'($urandom), 1'b1, acc);
      end
      repeat (3) step(1'b0, 4'b0, 4'b0, OP_AND, 1'b1, acc);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
